// File: rtl/w0rm_mem_arb_pkg.sv
// Shared definitions for the w0rm memory-port arbiter.
// Contents: transaction state encoding and a ceil(log2) helper used to
// size index and counter fields.
package w0rm_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // ceil(log2(value)), never less than 1 so it can size a vector directly
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/w0rm_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   eligible   - per-requester eligibility vector
//   last_grant - index granted on the previous accept; search starts one above
//   grant      - one-hot winner (all zero when nothing is eligible)
//   grant_idx  - encoded winner index
//   any_grant  - at least one requester is eligible
module w0rm_rr_arbiter
    import w0rm_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    int unsigned cand;

    // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first eligible wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_grant && eligible[IDX_W'(cand)]) begin
                any_grant              = 1'b1;
                grant_idx              = IDX_W'(cand);
                grant[IDX_W'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// Round-robin arbiter sharing one W0RM memory-block port between NUM_REQ
// requesters, one transaction at a time (IDLE -> ISSUE -> WAIT -> IDLE).
// Optional macro W0RM_MEM_ARB_TIMEOUT_EN: completes accesses the memory
// drops with an error response after TIMEOUT_CYCLES WAIT cycles.
// Ports:
//   mem_clk, cpu_reset_n         - clock, async active-low reset
//   req_*_i                      - flattened per-requester request fields
//   req_ready_o                  - one-hot accept (combinational, IDLE only)
//   rsp_valid_o/data/user/err    - one-cycle response to the granted requester
//   mem_valid_o/read/write/addr/data/user_o - request to the memory
//   mem_valid_i, mem_data_i      - memory response
//   busy_o                       - transaction in flight
module w0rm_mem_arbiter
    import w0rm_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned USER_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                          mem_clk,
    input  logic                          cpu_reset_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_read_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ*USER_WIDTH-1:0] req_user_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [USER_WIDTH-1:0]         rsp_user_o,
    output logic                          rsp_err_o,
    output logic                          mem_valid_o,
    output logic                          mem_read_o,
    output logic                          mem_write_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_data_o,
    output logic [USER_WIDTH-1:0]         mem_user_o,
    input  logic                          mem_valid_i,
    input  logic [DATA_WIDTH-1:0]         mem_data_i,
    output logic                          busy_o
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("w0rm_mem_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       last_grant_q;
    logic [IDX_W-1:0]       owner_q;
    logic                   any_grant;
    logic                   accept;
    logic                   complete;
    logic                   timeout;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [USER_WIDTH-1:0]  sel_user;
    logic                   sel_read;
    logic                   sel_write;

    assign eligible = req_valid_i & (req_read_i | req_write_i);

    w0rm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // Reset gates the accept so req_ready_o reads 0 while held in reset
    assign accept      = (state_q == ST_IDLE) && any_grant && cpu_reset_n;
    assign req_ready_o = accept ? grant : '0;
    assign complete    = (state_q == ST_WAIT) && (mem_valid_i || timeout);

    // Select the winning requester's fields
    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_user  = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_addr  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = req_user_i[k*USER_WIDTH +: USER_WIDTH];
                sel_read  = req_read_i[k];
                sel_write = req_write_i[k];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_ISSUE;
            ST_ISSUE:               state_d = ST_WAIT;
            ST_WAIT:  if (complete) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            busy_o       <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_user_o   <= '0;
            rsp_valid_o  <= '0;
            rsp_data_o   <= '0;
            rsp_user_o   <= '0;
        end else begin
            state_q     <= state_d;
            busy_o      <= (state_d != ST_IDLE);
            mem_valid_o <= (state_d == ST_ISSUE);
            rsp_valid_o <= '0;
            if (accept) begin
                last_grant_q <= grant_idx;
                owner_q      <= grant_idx;
                mem_read_o   <= sel_read;
                mem_write_o  <= sel_write;
                mem_addr_o   <= sel_addr;
                mem_data_o   <= sel_data;
                mem_user_o   <= sel_user;
            end
            if (complete) begin
                rsp_valid_o <= NUM_REQ'(1) << owner_q;
                rsp_data_o  <= mem_valid_i ? mem_data_i : '0;
                rsp_user_o  <= mem_user_o;
            end
        end
    end

`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // to_cnt_q counts earlier WAIT cycles, so TIMEOUT_CYCLES-1 marks the limit cycle
    assign timeout = (state_q == ST_WAIT) && !mem_valid_i &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter and error flag
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            to_cnt_q  <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && !complete) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (complete) begin
                rsp_err_o <= !mem_valid_i;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

endmodule
